btb_fetch_unit: RTL and testbench

//   IF-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors.

---
 rtl/btb_fetch_if.sv | 27 ++
 rtl/btb_fetch_unit.sv | 99 +++++++++
 tb/tb_btb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_fetch_if.sv
// Fetch-stage bundle: hazard/EX control and BTB training into the PC generator,
// fetch PC and prediction back out toward IF-ID.
interface btb_fetch_if;
    logic        stall_f;
    logic        redirect_e;
    logic [31:0] redirect_target_e;
    logic        upd_valid_e;
    logic [31:0] upd_pc_e;
    logic [31:0] upd_target_e;
    logic        upd_taken_e;
    logic [31:0] PCF;
    logic        BranchPredictedF;
    logic        btb_hit_f;

    // master: pipeline side (hazard unit, EX stage) driving the fetch unit
    modport master (
        output stall_f, redirect_e, redirect_target_e,
        output upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e,
        input  PCF, BranchPredictedF, btb_hit_f
    );

    modport slave (
        input  stall_f, redirect_e, redirect_target_e,
        input  upd_valid_e, upd_pc_e, upd_target_e, upd_taken_e,
        output PCF, BranchPredictedF, btb_hit_f
    );
endinterface

// File: rtl/btb_fetch_unit.sv
// IF-stage PC generator with a direct-mapped BTB and 2-bit saturating predictors,
// trained every cycle by the branch resolved in EX.
module btb_fetch_unit #(
    parameter int          ENTRIES  = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst_n,
    btb_fetch_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11)
            res = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            res = ctr - 2'b01;
        return res;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [31:0]      pc_q;
    logic [31:0]      pc_nxt;
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_pred;
    logic [31:0]      f_target;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    logic unused_bits;
    assign unused_bits = ^{bus.upd_pc_e[1:0], bus.upd_target_e[1:0]};

    // Fetch lookup: combinational read of the pre-edge BTB contents at PCF
    assign f_idx    = pc_q[IDX_W+1:2];
    assign f_tag    = pc_q[31:IDX_W+2];
    assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_pred   = f_hit && ctr_q[f_idx][1];
    assign f_target = {tgt_q[f_idx], 2'b00};

    assign bus.PCF              = pc_q;
    assign bus.btb_hit_f        = rst_n && f_hit;
    assign bus.BranchPredictedF = rst_n && f_pred;

    // EX redirect beats stall; a held PC ignores its own prediction
    always_comb begin
        pc_nxt = pc_q + 32'd4;
        if (bus.redirect_e)
            pc_nxt = bus.redirect_target_e & ~32'd3;
        else if (bus.stall_f)
            pc_nxt = pc_q;
        else if (f_pred)
            pc_nxt = f_target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_nxt;
    end

    // Training port: single write per cycle, independent of stall/redirect
    assign u_idx = bus.upd_pc_e[IDX_W+1:2];
    assign u_tag = bus.upd_pc_e[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_ff @(posedge clk) begin
        if (!rst_n)
            valid_q <= '0;
        else if (bus.upd_valid_e && !u_hit && bus.upd_taken_e)
            valid_q[u_idx] <= 1'b1;
    end

    // Payload arrays carry no reset; valid_q alone qualifies them
    always_ff @(posedge clk) begin
        if (rst_n && bus.upd_valid_e) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_train(ctr_q[u_idx], bus.upd_taken_e);
                if (bus.upd_taken_e)
                    tgt_q[u_idx] <= bus.upd_target_e[31:2];
            end else if (bus.upd_taken_e) begin
                tag_q[u_idx] <= u_tag;
                tgt_q[u_idx] <= bus.upd_target_e[31:2];
                ctr_q[u_idx] <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_btb_fetch_unit.sv
// Directed bench for btb_fetch_unit: reset, prediction, counter training,
// aliasing, stall/redirect priority, same-cycle update and PC wrap.
module tb_btb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    btb_fetch_if bus();

    btb_fetch_unit #(.ENTRIES(64), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        bus.redirect_e        = 1'b1;
        bus.redirect_target_e = addr;
        step();
        bus.redirect_e        = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = pc;
        bus.upd_target_e = tgt;
        bus.upd_taken_e  = taken;
        step();
        bus.upd_valid_e  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        bus.stall_f = 0; bus.redirect_e = 0; bus.redirect_target_e = 0;
        bus.upd_valid_e = 0; bus.upd_pc_e = 0; bus.upd_target_e = 0; bus.upd_taken_e = 0;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.BranchPredictedF !== 1'b0 || bus.btb_hit_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs pred=%b hit=%b expected 0 0", bus.BranchPredictedF, bus.btb_hit_f);
        end
        rst_n = 1'b1;
        n_checks++;
        if (bus.PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc PCF=%h expected 00000000", bus.PCF);
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 32'd4;
            n_checks++;
            if (bus.PCF !== exp_pc || bus.BranchPredictedF !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_seq PCF=%h pred=%b expected %h 0", bus.PCF, bus.BranchPredictedF, exp_pc);
            end
        end
    endtask

    task automatic test_predict_taken();
        // PCF is 0x0C; this edge trains 0x10 and moves PCF to 0x10
        train(32'h10, 32'h40, 1'b1);
        n_checks++;
        if (bus.PCF !== 32'h10 || bus.BranchPredictedF !== 1'b1 || bus.btb_hit_f !== 1'b1) begin
            n_fail++;
            $display("FAIL predict_hit PCF=%h pred=%b hit=%b expected 00000010 1 1",
                     bus.PCF, bus.BranchPredictedF, bus.btb_hit_f);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h40) begin
            n_fail++;
            $display("FAIL predict_target PCF=%h expected 00000040", bus.PCF);
        end
    endtask

    task automatic test_counter();
        train(32'h10, 32'h99C, 1'b0);
        train(32'h10, 32'h99C, 1'b0);
        goto_pc(32'h10);
        n_checks++;
        if (bus.btb_hit_f !== 1'b1 || bus.BranchPredictedF !== 1'b0) begin
            n_fail++;
            $display("FAIL ctr_nt hit=%b pred=%b expected 1 0", bus.btb_hit_f, bus.BranchPredictedF);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h14) begin
            n_fail++;
            $display("FAIL ctr_nt_next PCF=%h expected 00000014", bus.PCF);
        end
        // Clamp at 00, then one taken -> 01 still predicts not-taken
        train(32'h10, 32'h99C, 1'b0);
        train(32'h10, 32'h40, 1'b1);
        goto_pc(32'h10);
        n_checks++;
        if (bus.btb_hit_f !== 1'b1 || bus.BranchPredictedF !== 1'b0) begin
            n_fail++;
            $display("FAIL ctr_floor hit=%b pred=%b expected 1 0", bus.btb_hit_f, bus.BranchPredictedF);
        end
        // 01 -> 10 -> 11 -> 11, then one not-taken -> 10 still predicts taken
        train(32'h10, 32'h40, 1'b1);
        train(32'h10, 32'h40, 1'b1);
        train(32'h10, 32'h40, 1'b1);
        train(32'h10, 32'h300, 1'b0);
        goto_pc(32'h10);
        n_checks++;
        if (bus.BranchPredictedF !== 1'b1) begin
            n_fail++;
            $display("FAIL ctr_ceiling pred=%b expected 1", bus.BranchPredictedF);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h40) begin
            n_fail++;
            $display("FAIL ctr_target_kept PCF=%h expected 00000040", bus.PCF);
        end
    endtask

    task automatic test_alias();
        train(32'h110, 32'h80, 1'b1);
        goto_pc(32'h10);
        n_checks++;
        if (bus.btb_hit_f !== 1'b0 || bus.BranchPredictedF !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_evicted hit=%b pred=%b expected 0 0", bus.btb_hit_f, bus.BranchPredictedF);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h14) begin
            n_fail++;
            $display("FAIL alias_evicted_next PCF=%h expected 00000014", bus.PCF);
        end
        goto_pc(32'h110);
        n_checks++;
        if (bus.btb_hit_f !== 1'b1 || bus.BranchPredictedF !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_new hit=%b pred=%b expected 1 1", bus.btb_hit_f, bus.BranchPredictedF);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h80) begin
            n_fail++;
            $display("FAIL alias_new_target PCF=%h expected 00000080", bus.PCF);
        end
    endtask

    task automatic test_stall_redirect();
        goto_pc(32'h300);
        bus.stall_f           = 1'b1;
        bus.redirect_e        = 1'b1;
        bus.redirect_target_e = 32'h203;
        step();
        bus.redirect_e        = 1'b0;
        n_checks++;
        if (bus.PCF !== 32'h200) begin
            n_fail++;
            $display("FAIL stall_redirect PCF=%h expected 00000200", bus.PCF);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.PCF !== 32'h200) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d PCF=%h expected 00000200", i, bus.PCF);
            end
        end
        bus.stall_f = 1'b0;
        step();
        n_checks++;
        if (bus.PCF !== 32'h204) begin
            n_fail++;
            $display("FAIL stall_release PCF=%h expected 00000204", bus.PCF);
        end
    endtask

    task automatic test_same_cycle_update();
        goto_pc(32'h500);
        bus.stall_f      = 1'b1;
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = 32'h500;
        bus.upd_target_e = 32'h600;
        bus.upd_taken_e  = 1'b1;
        #1;
        n_checks++;
        if (bus.btb_hit_f !== 1'b0 || bus.BranchPredictedF !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_old hit=%b pred=%b expected 0 0", bus.btb_hit_f, bus.BranchPredictedF);
        end
        step();
        bus.upd_valid_e = 1'b0;
        n_checks++;
        if (bus.PCF !== 32'h500 || bus.btb_hit_f !== 1'b1 || bus.BranchPredictedF !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_new PCF=%h hit=%b pred=%b expected 00000500 1 1",
                     bus.PCF, bus.btb_hit_f, bus.BranchPredictedF);
        end
        bus.stall_f = 1'b0;
        step();
        n_checks++;
        if (bus.PCF !== 32'h600) begin
            n_fail++;
            $display("FAIL same_cycle_target PCF=%h expected 00000600", bus.PCF);
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        step();
        n_checks++;
        if (bus.PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap PCF=%h expected 00000000", bus.PCF);
        end
    endtask

    task automatic test_reset_priority();
        rst_n            = 1'b0;
        bus.upd_valid_e  = 1'b1;
        bus.upd_pc_e     = 32'h700;
        bus.upd_target_e = 32'h740;
        bus.upd_taken_e  = 1'b1;
        step();
        bus.upd_valid_e  = 1'b0;
        rst_n            = 1'b1;
        n_checks++;
        if (bus.PCF !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_prio_pc PCF=%h expected 00000000", bus.PCF);
        end
        goto_pc(32'h110);
        n_checks++;
        if (bus.btb_hit_f !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_clears_valid hit=%b expected 0", bus.btb_hit_f);
        end
        goto_pc(32'h700);
        n_checks++;
        if (bus.btb_hit_f !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drops_update hit=%b expected 0", bus.btb_hit_f);
        end
        step();
        n_checks++;
        if (bus.PCF !== 32'h704) begin
            n_fail++;
            $display("FAIL rst_drops_update_next PCF=%h expected 00000704", bus.PCF);
        end
    endtask

    initial begin
        test_reset();
        test_predict_taken();
        test_counter();
        test_alias();
        test_stall_redirect();
        test_same_cycle_update();
        test_wrap();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
